// File: rtl/ifetcher.sv
// Instruction fetcher: keeps one icache request in flight and buffers the returned
// {pc, inst} pairs in a circular queue for the dispatcher; a flush redirects the fetch PC.
module ifetcher #(
   parameter int          QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        ic_req,
   output logic [31:0] ic_addr,
   input  logic        ic_ready,
   input  logic        ic_valid,
   input  logic [31:0] ic_inst,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        issue_ready,
   input  logic        flush,
   input  logic [31:0] flush_pc
);
   localparam int DATA_W = 32;
   localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W  = $clog2(QDEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t            state_r, state_nx;
   logic [DATA_W-1:0] fetch_pc_r, fetch_pc_nx;
   logic [DATA_W-1:0] req_pc_r, req_pc_nx;
   logic [PTR_W-1:0]  head_r, head_nx;
   logic [PTR_W-1:0]  tail_r, tail_nx;
   logic [CNT_W-1:0]  count_r, count_nx;
   logic [DATA_W-1:0] q_pc   [QDEPTH];
   logic [DATA_W-1:0] q_inst [QDEPTH];
   logic              q_empty, q_full, push, pop;

   // QDEPTH is a power of two, so the natural pointer overflow is the modulo wrap.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return p + PTR_W'(1);
   endfunction

   assign q_empty = (count_r == '0);
   assign q_full  = (count_r == FULL_CNT);

   assign ic_req   = rst && rdy && !flush && (state_r == IDLE) && !q_full;
   assign ic_addr  = fetch_pc_r;
   assign if_valid = rst && rdy && !q_empty;
   assign if_pc    = (!rst || q_empty) ? '0 : q_pc[head_r];
   assign if_inst  = (!rst || q_empty) ? '0 : q_inst[head_r];

   // Flush outranks everything: no push, no pop in the redirect cycle.
   assign push = rst && rdy && !flush && (state_r == WAIT) && ic_valid;
   assign pop  = if_valid && issue_ready && !flush;

   always_comb begin
      state_nx    = state_r;
      fetch_pc_nx = fetch_pc_r;
      req_pc_nx   = req_pc_r;
      head_nx     = head_r;
      tail_nx     = tail_r;
      count_nx    = count_r;
      if (rdy) begin
         if (flush) begin
            fetch_pc_nx = flush_pc;
            head_nx     = '0;
            tail_nx     = '0;
            count_nx    = '0;
            // An in-flight request must still drain; its response is thrown away.
            case (state_r)
               WAIT:    state_nx = ic_valid ? IDLE : DROP;
               DROP:    state_nx = ic_valid ? IDLE : DROP;
               default: state_nx = IDLE;
            endcase
         end else begin
            case (state_r)
               IDLE: begin
                  if (ic_req && ic_ready) begin
                     state_nx  = WAIT;
                     req_pc_nx = fetch_pc_r;
                  end
               end
               WAIT: begin
                  if (ic_valid) begin
                     state_nx    = IDLE;
                     fetch_pc_nx = req_pc_r + 32'd4;
                  end
               end
               DROP: begin
                  if (ic_valid) state_nx = IDLE;
               end
               default: state_nx = IDLE;
            endcase
            if (push) tail_nx = ptr_inc(tail_r);
            if (pop)  head_nx = ptr_inc(head_r);
            case ({push, pop})
               2'b10:   count_nx = count_r + CNT_W'(1);
               2'b01:   count_nx = count_r - CNT_W'(1);
               default: count_nx = count_r;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= IDLE;
         fetch_pc_r <= RESET_PC;
         req_pc_r   <= '0;
         head_r     <= '0;
         tail_r     <= '0;
         count_r    <= '0;
      end else if (rdy) begin
         state_r    <= state_nx;
         fetch_pc_r <= fetch_pc_nx;
         req_pc_r   <= req_pc_nx;
         head_r     <= head_nx;
         tail_r     <= tail_nx;
         count_r    <= count_nx;
      end
   end

   // Queue storage carries data only; occupancy is tracked by count_r.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[tail_r]   <= req_pc_r;
         q_inst[tail_r] <= ic_inst;
      end
   end

endmodule
